// File: rtl/rob_pkg.sv
// Shared constants, types and bus packing helpers for the rename stage.
// Flat buses carry slot/register 0 in the most significant field; the
// helpers convert them to packed arrays indexed by slot number.
package rob_pkg;

    localparam int NUM_REGS = 16;
    localparam int DATA_W   = 16;
    localparam int TAG_W    = 4;
    localparam int WIDTH    = 4;
    localparam int ROB_SIZE = 16;
    localparam int REG_W    = $clog2(NUM_REGS);

    typedef logic [REG_W-1:0]  reg_idx_t;
    typedef logic [TAG_W-1:0]  rob_tag_t;
    typedef logic [DATA_W-1:0] data_t;

    // Element [i] of these arrays always belongs to slot i.
    typedef reg_idx_t [WIDTH-1:0] reg_slots_t;
    typedef rob_tag_t [WIDTH-1:0] tag_slots_t;
    typedef data_t    [WIDTH-1:0] data_slots_t;

    function automatic logic [WIDTH-1:0] unflatten_bits(input logic [WIDTH-1:0] flat);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = flat[WIDTH-1-i];
        return r;
    endfunction

    function automatic reg_slots_t unflatten_regs(input logic [WIDTH*REG_W-1:0] flat);
        reg_slots_t packed_v;
        reg_slots_t r;
        packed_v = flat;
        for (int i = 0; i < WIDTH; i++) r[i] = packed_v[WIDTH-1-i];
        return r;
    endfunction

    function automatic tag_slots_t unflatten_tags(input logic [WIDTH*TAG_W-1:0] flat);
        tag_slots_t packed_v;
        tag_slots_t r;
        packed_v = flat;
        for (int i = 0; i < WIDTH; i++) r[i] = packed_v[WIDTH-1-i];
        return r;
    endfunction

    function automatic data_slots_t unflatten_data(input logic [WIDTH*DATA_W-1:0] flat);
        data_slots_t packed_v;
        data_slots_t r;
        packed_v = flat;
        for (int i = 0; i < WIDTH; i++) r[i] = packed_v[WIDTH-1-i];
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] flatten_bits(input logic [WIDTH-1:0] slots);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[WIDTH-1-i] = slots[i];
        return r;
    endfunction

    function automatic logic [WIDTH*TAG_W-1:0] flatten_tags(input tag_slots_t slots);
        tag_slots_t r;
        for (int i = 0; i < WIDTH; i++) r[WIDTH-1-i] = slots[i];
        return r;
    endfunction

    function automatic logic [WIDTH*DATA_W-1:0] flatten_data(input data_slots_t slots);
        data_slots_t r;
        for (int i = 0; i < WIDTH; i++) r[WIDTH-1-i] = slots[i];
        return r;
    endfunction

endpackage

// File: rtl/operand_lookup.sv
// Resolves one source operand: base state read, then commit bypass, then
// intra-group rename (highest priority). r0 always reads as ready zero.
module operand_lookup
    import rob_pkg::*;
(
    input  reg_idx_t         src,
    input  logic             base_busy,
    input  data_t            base_value,
    input  rob_tag_t         base_tag,
    input  logic [WIDTH-1:0] commit_en,
    input  reg_slots_t       commit_target,
    input  data_slots_t      commit_data,
    input  tag_slots_t       commit_writer,
    input  logic [WIDTH-1:0] earlier_valid,
    input  reg_slots_t       earlier_dest,
    input  tag_slots_t       earlier_tag,
    output logic             ready,
    output data_t            value,
    output rob_tag_t         tag
);

    // Priority chain; later assignments override earlier ones.
    always_comb begin
        ready = !base_busy;
        value = base_value;
        tag   = base_tag;

        // A commit of the current producer makes the value usable now.
        if (base_busy) begin
            for (int k = 0; k < WIDTH; k++) begin
                if (commit_en[k] && (commit_target[k] == src) &&
                    (commit_writer[k] == base_tag)) begin
                    ready = 1'b1;
                    value = commit_data[k];
                end
            end
        end

        // Ascending scan so the nearest earlier writer is the one kept.
        for (int j = 0; j < WIDTH; j++) begin
            if (earlier_valid[j] && (earlier_dest[j] == src) && (src != '0)) begin
                ready = 1'b0;
                tag   = earlier_tag[j];
            end
        end

        if (src == '0) begin
            ready = 1'b1;
            value = '0;
            tag   = '0;
        end
    end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file plus alias table. Up to WIDTH in-order
// instructions per cycle read operands and rename their destinations;
// the ROB commit ports write values back and retire busy state.
// dispatch_valid is an unconditional strobe: there is no ready/backpressure,
// a valid slot is consumed on the edge it is presented.
module rename_regfile
    import rob_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        dispatch_valid_flat,
    input  logic [WIDTH*REG_W-1:0]  dispatch_dest_flat,
    input  logic [WIDTH*REG_W-1:0]  dispatch_src_a_flat,
    input  logic [WIDTH*REG_W-1:0]  dispatch_src_b_flat,
    input  logic [TAG_W-1:0]        rob_head,
    input  logic [WIDTH-1:0]        commit_enable_flat,
    input  logic [WIDTH*REG_W-1:0]  commit_targets_flat,
    input  logic [WIDTH*DATA_W-1:0] commit_data_flat,
    input  logic [WIDTH*TAG_W-1:0]  commit_writers_flat,
    output logic [WIDTH-1:0]        src_a_ready_flat,
    output logic [WIDTH*DATA_W-1:0] src_a_value_flat,
    output logic [WIDTH*TAG_W-1:0]  src_a_tag_flat,
    output logic [WIDTH-1:0]        src_b_ready_flat,
    output logic [WIDTH*DATA_W-1:0] src_b_value_flat,
    output logic [WIDTH*TAG_W-1:0]  src_b_tag_flat,
    output logic [NUM_REGS-1:0]     busy_flat
);

    // Architectural state, indexed by register number.
    data_t    [NUM_REGS-1:0] value_q, value_d;
    rob_tag_t [NUM_REGS-1:0] tag_q,   tag_d;
    logic     [NUM_REGS-1:0] busy_q,  busy_d;

    // Per-slot views of the flat buses.
    logic [WIDTH-1:0] disp_valid;
    reg_slots_t       disp_dest, disp_src_a, disp_src_b;
    logic [WIDTH-1:0] commit_en;
    reg_slots_t       commit_target;
    data_slots_t      commit_data;
    tag_slots_t       commit_writer;

    assign disp_valid    = unflatten_bits(dispatch_valid_flat);
    assign disp_dest     = unflatten_regs(dispatch_dest_flat);
    assign disp_src_a    = unflatten_regs(dispatch_src_a_flat);
    assign disp_src_b    = unflatten_regs(dispatch_src_b_flat);
    assign commit_en     = unflatten_bits(commit_enable_flat);
    assign commit_target = unflatten_regs(commit_targets_flat);
    assign commit_data   = unflatten_data(commit_data_flat);
    assign commit_writer = unflatten_tags(commit_writers_flat);

    // Slot tags: rob_head plus the count of valid older slots, wrapping mod ROB_SIZE.
    tag_slots_t slot_tag;
    rob_tag_t   tag_offset;

    always_comb begin
        slot_tag   = '0;
        tag_offset = '0;
        for (int i = 0; i < WIDTH; i++) begin
            slot_tag[i] = rob_head + tag_offset;
            if (disp_valid[i]) tag_offset = tag_offset + rob_tag_t'(1);
        end
    end

    // Mask of valid older slots seen by each slot's operand lookups.
    logic [WIDTH-1:0] earlier_valid [WIDTH];

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            earlier_valid[i] = '0;
            for (int j = 0; j < WIDTH; j++) begin
                if (j < i) earlier_valid[i][j] = disp_valid[j];
            end
        end
    end

    logic [WIDTH-1:0] a_ready, b_ready;
    data_slots_t      a_value, b_value;
    tag_slots_t       a_tag,   b_tag;

    for (genvar g = 0; g < WIDTH; g++) begin : g_slot
        operand_lookup u_lookup_a (
            .src           (disp_src_a[g]),
            .base_busy     (busy_q[disp_src_a[g]]),
            .base_value    (value_q[disp_src_a[g]]),
            .base_tag      (tag_q[disp_src_a[g]]),
            .commit_en     (commit_en),
            .commit_target (commit_target),
            .commit_data   (commit_data),
            .commit_writer (commit_writer),
            .earlier_valid (earlier_valid[g]),
            .earlier_dest  (disp_dest),
            .earlier_tag   (slot_tag),
            .ready         (a_ready[g]),
            .value         (a_value[g]),
            .tag           (a_tag[g])
        );

        operand_lookup u_lookup_b (
            .src           (disp_src_b[g]),
            .base_busy     (busy_q[disp_src_b[g]]),
            .base_value    (value_q[disp_src_b[g]]),
            .base_tag      (tag_q[disp_src_b[g]]),
            .commit_en     (commit_en),
            .commit_target (commit_target),
            .commit_data   (commit_data),
            .commit_writer (commit_writer),
            .earlier_valid (earlier_valid[g]),
            .earlier_dest  (disp_dest),
            .earlier_tag   (slot_tag),
            .ready         (b_ready[g]),
            .value         (b_value[g]),
            .tag           (b_tag[g])
        );
    end

    assign src_a_ready_flat = flatten_bits(a_ready);
    assign src_a_value_flat = flatten_data(a_value);
    assign src_a_tag_flat   = flatten_tags(a_tag);
    assign src_b_ready_flat = flatten_bits(b_ready);
    assign src_b_value_flat = flatten_data(b_value);
    assign src_b_tag_flat   = flatten_tags(b_tag);

    // Busy bits out with r0 in the MSB.
    always_comb begin
        busy_flat = '0;
        for (int r = 0; r < NUM_REGS; r++) busy_flat[NUM_REGS-1-r] = busy_q[r];
    end

    // Next state: commits first, then dispatch renames override busy/tag.
    always_comb begin
        value_d = value_q;
        busy_d  = busy_q;
        tag_d   = tag_q;

        // Youngest commit slot to a register leaves its data last.
        for (int k = 0; k < WIDTH; k++) begin
            if (commit_en[k] && (commit_target[k] != '0)) begin
                value_d[commit_target[k]] = commit_data[k];
                if (commit_writer[k] == tag_q[commit_target[k]]) begin
                    busy_d[commit_target[k]] = 1'b0;
                end
            end
        end

        // Youngest dispatch to a register leaves its tag last.
        for (int i = 0; i < WIDTH; i++) begin
            if (disp_valid[i] && (disp_dest[i] != '0)) begin
                busy_d[disp_dest[i]] = 1'b1;
                tag_d[disp_dest[i]]  = slot_tag[i];
            end
        end
    end

    // State register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
            busy_q  <= '0;
            tag_q   <= '0;
        end else begin
            value_q <= value_d;
            busy_q  <= busy_d;
            tag_q   <= tag_d;
        end
    end

endmodule

// File: tb/tb_rename_regfile.sv
// Bench for rename_regfile: directed scenarios followed by randomized
// traffic compared against a register-level behavioural model.
module tb_rename_regfile;

  logic        clk;
  logic        rst;
  logic [3:0]  dispatch_valid_flat;
  logic [15:0] dispatch_dest_flat;
  logic [15:0] dispatch_src_a_flat;
  logic [15:0] dispatch_src_b_flat;
  logic [3:0]  rob_head;
  logic [3:0]  commit_enable_flat;
  logic [15:0] commit_targets_flat;
  logic [63:0] commit_data_flat;
  logic [15:0] commit_writers_flat;
  logic [3:0]  src_a_ready_flat;
  logic [63:0] src_a_value_flat;
  logic [15:0] src_a_tag_flat;
  logic [3:0]  src_b_ready_flat;
  logic [63:0] src_b_value_flat;
  logic [15:0] src_b_tag_flat;
  logic [15:0] busy_flat;

  rename_regfile dut (
    .clk                 (clk),
    .rst                 (rst),
    .dispatch_valid_flat (dispatch_valid_flat),
    .dispatch_dest_flat  (dispatch_dest_flat),
    .dispatch_src_a_flat (dispatch_src_a_flat),
    .dispatch_src_b_flat (dispatch_src_b_flat),
    .rob_head            (rob_head),
    .commit_enable_flat  (commit_enable_flat),
    .commit_targets_flat (commit_targets_flat),
    .commit_data_flat    (commit_data_flat),
    .commit_writers_flat (commit_writers_flat),
    .src_a_ready_flat    (src_a_ready_flat),
    .src_a_value_flat    (src_a_value_flat),
    .src_a_tag_flat      (src_a_tag_flat),
    .src_b_ready_flat    (src_b_ready_flat),
    .src_b_value_flat    (src_b_value_flat),
    .src_b_tag_flat      (src_b_tag_flat),
    .busy_flat           (busy_flat)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus state (slot-indexed) ----------------
  logic        dv[4];
  logic [3:0]  dd[4], da[4], db[4];
  logic [3:0]  head;
  logic        ce[4];
  logic [3:0]  ct[4], cw[4];
  logic [15:0] cd[4];

  // ---------------- reference model state ----------------
  logic [15:0] m_val[16];
  logic        m_busy[16];
  logic [3:0]  m_tag[16];

  int checks;
  int failures;
  logic [20:0] exp_q[$];

  // ---------------- observation helpers ----------------
  logic [3:0][15:0] a_val_v, b_val_v;
  logic [3:0][3:0]  a_tag_v, b_tag_v;
  assign a_val_v = src_a_value_flat;
  assign b_val_v = src_b_value_flat;
  assign a_tag_v = src_a_tag_flat;
  assign b_tag_v = src_b_tag_flat;

  function automatic logic obs_ready(input int s, input bit is_b);
    return is_b ? src_b_ready_flat[3-s] : src_a_ready_flat[3-s];
  endfunction

  function automatic logic [15:0] obs_value(input int s, input bit is_b);
    return is_b ? b_val_v[3-s] : a_val_v[3-s];
  endfunction

  function automatic logic [3:0] obs_tag(input int s, input bit is_b);
    return is_b ? b_tag_v[3-s] : a_tag_v[3-s];
  endfunction

  function automatic logic obs_busy(input int r);
    return busy_flat[15-r];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive();
    dispatch_valid_flat = {dv[0], dv[1], dv[2], dv[3]};
    dispatch_dest_flat  = {dd[0], dd[1], dd[2], dd[3]};
    dispatch_src_a_flat = {da[0], da[1], da[2], da[3]};
    dispatch_src_b_flat = {db[0], db[1], db[2], db[3]};
    rob_head            = head;
    commit_enable_flat  = {ce[0], ce[1], ce[2], ce[3]};
    commit_targets_flat = {ct[0], ct[1], ct[2], ct[3]};
    commit_data_flat    = {cd[0], cd[1], cd[2], cd[3]};
    commit_writers_flat = {cw[0], cw[1], cw[2], cw[3]};
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 4; i++) begin
      dv[i] = 1'b0; dd[i] = 4'h0; da[i] = 4'h0; db[i] = 4'h0;
      ce[i] = 1'b0; ct[i] = 4'h0; cw[i] = 4'h0; cd[i] = 16'h0;
    end
    head = 4'h0;
    drive();
  endtask

  // ---------------- reference model ----------------
  // ROB index of slot i: head plus how many older slots are valid.
  function automatic logic [3:0] m_slot_tag(input int i);
    int c;
    c = 0;
    for (int j = 0; j < i; j++) if (dv[j]) c++;
    return 4'((int'(head) + c) % 16);
  endfunction

  task automatic model_read(input int slot, input logic [3:0] r,
                            output logic rdy, output logic [15:0] val, output logic [3:0] tg);
    if (r == 4'h0) begin
      rdy = 1'b1; val = 16'h0; tg = 4'h0;
      return;
    end
    rdy = !m_busy[r];
    val = m_val[r];
    tg  = m_tag[r];
    if (m_busy[r]) begin
      for (int k = 0; k < 4; k++)
        if (ce[k] && ct[k] == r && cw[k] == m_tag[r]) begin
          rdy = 1'b1;
          val = cd[k];
        end
    end
    for (int j = slot - 1; j >= 0; j--) begin
      if (dv[j] && dd[j] == r) begin
        rdy = 1'b0;
        tg  = m_slot_tag(j);
        break;
      end
    end
  endtask

  // Applies one clock edge's worth of architectural effects, register by register.
  task automatic model_update();
    logic [15:0] nv[16];
    logic        nb[16];
    logic [3:0]  nt[16];
    logic        clr, renamed;
    if (rst) begin
      for (int r = 0; r < 16; r++) begin
        m_val[r] = 16'h0; m_busy[r] = 1'b0; m_tag[r] = 4'h0;
      end
      return;
    end
    for (int r = 0; r < 16; r++) begin
      nv[r] = m_val[r]; nb[r] = m_busy[r]; nt[r] = m_tag[r];
    end
    for (int r = 1; r < 16; r++) begin
      clr = 1'b0;
      renamed = 1'b0;
      for (int k = 0; k < 4; k++)
        if (ce[k] && ct[k] == 4'(r)) begin
          nv[r] = cd[k];
          if (cw[k] == m_tag[r]) clr = 1'b1;
        end
      for (int i = 0; i < 4; i++)
        if (dv[i] && dd[i] == 4'(r)) begin
          renamed = 1'b1;
          nt[r] = m_slot_tag(i);
        end
      if (renamed) nb[r] = 1'b1;
      else if (clr) nb[r] = 1'b0;
    end
    for (int r = 0; r < 16; r++) begin
      m_val[r] = nv[r]; m_busy[r] = nb[r]; m_tag[r] = nt[r];
    end
  endtask

  // One clock edge; the model advances with the DUT, inputs change after.
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
    da[0] = 4'd0; da[1] = 4'd5; da[2] = 4'd9; da[3] = 4'd15;
    db[0] = 4'd1; db[1] = 4'd2; db[2] = 4'd3; db[3] = 4'd4;
    drive();
    #1;
    checks++;
    if (busy_flat !== 16'h0) begin
      failures++;
      $display("FAIL reset_busy: got %h expected %h", busy_flat, 16'h0);
    end
    for (int s = 0; s < 4; s++) begin
      for (int op = 0; op < 2; op++) begin
        checks++;
        if (obs_ready(s, op[0]) !== 1'b1 || obs_value(s, op[0]) !== 16'h0) begin
          failures++;
          $display("FAIL reset_read s%0d op%0d: got rdy=%b val=%h expected rdy=1 val=0000",
                   s, op, obs_ready(s, op[0]), obs_value(s, op[0]));
        end
      end
    end
  endtask

  task automatic test_basic_dispatch();
    clear_inputs();
    head = 4'd5; dv[0] = 1'b1; dd[0] = 4'd3; da[0] = 4'd1;
    drive();
    #1;
    checks++;
    if (obs_ready(0, 0) !== 1'b1 || obs_value(0, 0) !== 16'h0) begin
      failures++;
      $display("FAIL basic_src_a: got rdy=%b val=%h expected rdy=1 val=0000",
               obs_ready(0, 0), obs_value(0, 0));
    end
    tick();
    clear_inputs();
    da[0] = 4'd3;
    drive();
    #1;
    checks++;
    if (busy_flat !== 16'h1000) begin
      failures++;
      $display("FAIL basic_busy: got %h expected %h", busy_flat, 16'h1000);
    end
    checks++;
    if (obs_ready(0, 0) !== 1'b0 || obs_tag(0, 0) !== 4'd5) begin
      failures++;
      $display("FAIL basic_tag: got rdy=%b tag=%0d expected rdy=0 tag=5",
               obs_ready(0, 0), obs_tag(0, 0));
    end
  endtask

  task automatic test_group_wrap();
    // slot1 invalid: slot3 gets 14 + 1 = 15.
    clear_inputs();
    head = 4'd14;
    dv[0] = 1'b1; dd[0] = 4'd2;
    da[2] = 4'd2;
    dv[3] = 1'b1; dd[3] = 4'd4;
    drive();
    #1;
    checks++;
    if (obs_ready(2, 0) !== 1'b0 || obs_tag(2, 0) !== 4'd14) begin
      failures++;
      $display("FAIL group_rename: got rdy=%b tag=%0d expected rdy=0 tag=14",
               obs_ready(2, 0), obs_tag(2, 0));
    end
    tick();
    clear_inputs();
    da[0] = 4'd4;
    drive();
    #1;
    checks++;
    if (obs_ready(0, 0) !== 1'b0 || obs_tag(0, 0) !== 4'd15) begin
      failures++;
      $display("FAIL group_tag15: got rdy=%b tag=%0d expected rdy=0 tag=15",
               obs_ready(0, 0), obs_tag(0, 0));
    end
    // slot1 also valid: slot3 wraps to 0.
    clear_inputs();
    head = 4'd14;
    dv[0] = 1'b1; dd[0] = 4'd2;
    dv[1] = 1'b1; dd[1] = 4'd8;
    da[2] = 4'd2;
    dv[3] = 1'b1; dd[3] = 4'd4;
    drive();
    #1;
    checks++;
    if (obs_ready(2, 0) !== 1'b0 || obs_tag(2, 0) !== 4'd14) begin
      failures++;
      $display("FAIL group_rename2: got rdy=%b tag=%0d expected rdy=0 tag=14",
               obs_ready(2, 0), obs_tag(2, 0));
    end
    tick();
    clear_inputs();
    da[0] = 4'd4; db[0] = 4'd8;
    drive();
    #1;
    checks++;
    if (obs_ready(0, 0) !== 1'b0 || obs_tag(0, 0) !== 4'd0) begin
      failures++;
      $display("FAIL group_wrap0: got rdy=%b tag=%0d expected rdy=0 tag=0",
               obs_ready(0, 0), obs_tag(0, 0));
    end
    checks++;
    if (obs_ready(0, 1) !== 1'b0 || obs_tag(0, 1) !== 4'd15) begin
      failures++;
      $display("FAIL group_slot1_tag: got rdy=%b tag=%0d expected rdy=0 tag=15",
               obs_ready(0, 1), obs_tag(0, 1));
    end
  endtask

  task automatic test_commit_bypass();
    clear_inputs();
    head = 4'd7; dv[0] = 1'b1; dd[0] = 4'd2;
    drive();
    tick();
    clear_inputs();
    da[0] = 4'd2;
    ce[0] = 1'b1; ct[0] = 4'd2; cd[0] = 16'hBEEF; cw[0] = 4'd7;
    drive();
    #1;
    checks++;
    if (obs_ready(0, 0) !== 1'b1 || obs_value(0, 0) !== 16'hBEEF) begin
      failures++;
      $display("FAIL bypass_same_cycle: got rdy=%b val=%h expected rdy=1 val=beef",
               obs_ready(0, 0), obs_value(0, 0));
    end
    tick();
    clear_inputs();
    da[0] = 4'd2;
    drive();
    #1;
    checks++;
    if (obs_busy(2) !== 1'b0 || obs_ready(0, 0) !== 1'b1 || obs_value(0, 0) !== 16'hBEEF) begin
      failures++;
      $display("FAIL bypass_after: got busy=%b rdy=%b val=%h expected busy=0 rdy=1 val=beef",
               obs_busy(2), obs_ready(0, 0), obs_value(0, 0));
    end
  endtask

  task automatic test_stale_commit();
    clear_inputs();
    head = 4'd3; dv[0] = 1'b1; dd[0] = 4'd5;
    drive();
    tick();
    head = 4'd9;
    drive();
    tick();
    clear_inputs();
    da[0] = 4'd5;
    ce[0] = 1'b1; ct[0] = 4'd5; cd[0] = 16'h0011; cw[0] = 4'd3;
    drive();
    #1;
    checks++;
    if (obs_ready(0, 0) !== 1'b0 || obs_tag(0, 0) !== 4'd9) begin
      failures++;
      $display("FAIL stale_same_cycle: got rdy=%b tag=%0d expected rdy=0 tag=9",
               obs_ready(0, 0), obs_tag(0, 0));
    end
    tick();
    clear_inputs();
    da[0] = 4'd5;
    drive();
    #1;
    checks++;
    if (obs_busy(5) !== 1'b1 || obs_ready(0, 0) !== 1'b0 || obs_tag(0, 0) !== 4'd9) begin
      failures++;
      $display("FAIL stale_after: got busy=%b rdy=%b tag=%0d expected busy=1 rdy=0 tag=9",
               obs_busy(5), obs_ready(0, 0), obs_tag(0, 0));
    end
  endtask

  task automatic test_same_edge();
    clear_inputs();
    head = 4'd4; dv[0] = 1'b1; dd[0] = 4'd6;
    drive();
    tick();
    clear_inputs();
    ce[0] = 1'b1; ct[0] = 4'd6; cd[0] = 16'h1234; cw[0] = 4'd4;
    head = 4'd10; dv[0] = 1'b1; dd[0] = 4'd6;
    drive();
    tick();
    clear_inputs();
    da[0] = 4'd6;
    drive();
    #1;
    checks++;
    if (obs_busy(6) !== 1'b1 || obs_ready(0, 0) !== 1'b0 || obs_tag(0, 0) !== 4'd10) begin
      failures++;
      $display("FAIL same_edge: got busy=%b rdy=%b tag=%0d expected busy=1 rdy=0 tag=10",
               obs_busy(6), obs_ready(0, 0), obs_tag(0, 0));
    end
  endtask

  task automatic test_r0_and_reset();
    logic [15:0] busy_before;
    clear_inputs();
    #1;
    busy_before = busy_flat;
    dv[0] = 1'b1; dd[0] = 4'd0; head = 4'd11;
    da[1] = 4'd0;
    ce[0] = 1'b1; ct[0] = 4'd0; cd[0] = 16'h0041; cw[0] = 4'd0;
    drive();
    #1;
    checks++;
    if (obs_ready(1, 0) !== 1'b1 || obs_value(1, 0) !== 16'h0) begin
      failures++;
      $display("FAIL r0_read_same: got rdy=%b val=%h expected rdy=1 val=0000",
               obs_ready(1, 0), obs_value(1, 0));
    end
    tick();
    clear_inputs();
    db[2] = 4'd0;
    drive();
    #1;
    checks++;
    if (busy_flat !== busy_before || obs_ready(2, 1) !== 1'b1 || obs_value(2, 1) !== 16'h0) begin
      failures++;
      $display("FAIL r0_after: got busy=%h rdy=%b val=%h expected busy=%h rdy=1 val=0000",
               busy_flat, obs_ready(2, 1), obs_value(2, 1), busy_before);
    end
    rst = 1'b1;
    dv[0] = 1'b1; dd[0] = 4'd7; head = 4'd1;
    drive();
    tick();
    rst = 1'b0;
    clear_inputs();
    #1;
    checks++;
    if (busy_flat !== 16'h0) begin
      failures++;
      $display("FAIL midstream_reset: got busy=%h expected 0000", busy_flat);
    end
  endtask

  task automatic test_random();
    logic        rdy;
    logic [15:0] val;
    logic [3:0]  tg;
    logic [3:0]  r;
    logic [20:0] exp_w, obs_w;
    logic [15:0] exp_busy;
    logic        o_rdy;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst  = ($urandom_range(0, 63) == 0);
      head = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
        dv[i] = 1'($urandom_range(0, 1));
        dd[i] = 4'($urandom_range(0, 15));
        da[i] = 4'($urandom_range(0, 15));
        db[i] = 4'($urandom_range(0, 15));
        ce[i] = 1'($urandom_range(0, 1));
        ct[i] = 4'($urandom_range(0, 15));
        cd[i] = 16'($urandom);
        cw[i] = ($urandom_range(0, 3) != 0) ? m_tag[ct[i]] : 4'($urandom_range(0, 15));
      end
      drive();
      #1;
      for (int s = 0; s < 4; s++) begin
        for (int op = 0; op < 2; op++) begin
          r = op[0] ? db[s] : da[s];
          model_read(s, r, rdy, val, tg);
          exp_q.push_back({rdy, rdy ? 4'h0 : tg, rdy ? val : 16'h0});
          o_rdy = obs_ready(s, op[0]);
          obs_w = {o_rdy, o_rdy ? 4'h0 : obs_tag(s, op[0]), o_rdy ? obs_value(s, op[0]) : 16'h0};
          exp_w = exp_q.pop_front();
          checks++;
          if (obs_w !== exp_w) begin
            failures++;
            $display("FAIL random_operand cyc%0d s%0d op%0d r%0d: got %h expected %h",
                     cyc, s, op, r, obs_w, exp_w);
          end
        end
      end
      for (int k = 0; k < 16; k++) exp_busy[15-k] = m_busy[k];
      checks++;
      if (busy_flat !== exp_busy) begin
        failures++;
        $display("FAIL random_busy cyc%0d: got %h expected %h", cyc, busy_flat, exp_busy);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    for (int r = 0; r < 16; r++) begin
      m_val[r] = 16'h0; m_busy[r] = 1'b0; m_tag[r] = 4'h0;
    end
    clear_inputs();
    test_reset();
    test_basic_dispatch();
    test_group_wrap();
    test_commit_bypass();
    test_stale_commit();
    test_same_edge();
    test_r0_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
